// File: rtl/context_scheduler_pkg.sv
// Shared definitions for the context scheduler: FSM states, process count and
// the reset-time base PC of each process.
package reaper_pkg;

  localparam int unsigned PROC_N = 4;

  localparam int unsigned PROC_BASE_0 = 0;
  localparam int unsigned PROC_BASE_1 = 1024;
  localparam int unsigned PROC_BASE_2 = 2048;
  localparam int unsigned PROC_BASE_3 = 3072;

  typedef logic [1:0] proc_id_t;

  typedef enum logic [1:0] {
    StRun,
    StSwitch,
    StHold
  } sched_state_e;

  // Reset-time resume PC of a process.
  function automatic int unsigned proc_base(proc_id_t id);
    unique case (id)
      2'd0:    return PROC_BASE_0;
      2'd1:    return PROC_BASE_1;
      2'd2:    return PROC_BASE_2;
      default: return PROC_BASE_3;
    endcase
  endfunction

endpackage

// File: rtl/context_scheduler_rr_picker.sv
// Next-process selector: a valid runnable target wins, otherwise the first
// runnable process scanning round-robin from cur_id_i + 1.
module rr_picker
  import reaper_pkg::*;
(
  input  logic [PROC_N-1:0] mask_i,
  input  proc_id_t          cur_id_i,
  input  logic              target_en_i,
  input  proc_id_t          target_id_i,
  output proc_id_t          next_id_o
);

  proc_id_t cand;
  logic     found;

  // Scan cur+1 .. cur+4 (the last one wraps back to cur itself).
  always_comb begin
    next_id_o = cur_id_i;
    cand      = cur_id_i;
    found     = 1'b0;
    for (int unsigned k = 1; k <= PROC_N; k++) begin
      cand = cur_id_i + proc_id_t'(k);
      if (!found && mask_i[cand]) begin
        next_id_o = cand;
        found     = 1'b1;
      end
    end
    if (target_en_i && mask_i[target_id_i]) begin
      next_id_o = target_id_i;
    end
  end

endmodule

// File: rtl/context_scheduler.sv
// Time-sliced scheduler for four hardware contexts. Keeps a resume-PC per
// process, preempts on quantum expiry, honours software yields and parks
// while the processor is halted.
module context_scheduler
  import reaper_pkg::*;
#(
  parameter int unsigned SLICE_W = 16,
  parameter int unsigned PC_W    = 13
) (
  input  logic               Slow_Clock,
  input  logic               Reset,
  input  logic               Halt,
  input  logic [3:0]         Enable_Mask,
  input  logic [SLICE_W-1:0] Slice_Load,
  input  logic               Yield,
  input  logic               Target_Valid,
  input  logic [1:0]         Target_ID,
  input  logic [PC_W-1:0]    Current_PC,
  output logic               Change_Context,
  output logic [1:0]         Proc_ID,
  output logic [PC_W-1:0]    Context_PC,
  output logic [SLICE_W-1:0] Slice_Count
);

  sched_state_e       state_q, state_d;
  proc_id_t           proc_q, proc_d;
  logic [SLICE_W-1:0] slice_q, slice_d;
  logic [PC_W-1:0]    ctx_pc_q, ctx_pc_d;
  logic [PC_W-1:0]    pc_tbl_q [PROC_N];
  logic               tbl_we;

  logic [PROC_N-1:0]  runnable;
  logic               expired;
  logic               decide;
  proc_id_t           pick_id;

  // Process 0 is always runnable regardless of Enable_Mask[0].
  assign runnable = Enable_Mask | 4'b0001;
  assign expired  = (slice_q == SLICE_W'(1)) && (Slice_Load != '0);
  assign decide   = Yield || expired || !runnable[proc_q];

  rr_picker u_picker (
    .mask_i      (runnable),
    .cur_id_i    (proc_q),
    .target_en_i (Yield && Target_Valid),
    .target_id_i (Target_ID),
    .next_id_o   (pick_id)
  );

  // Next-state logic: scheduling decisions happen only in RUN.
  always_comb begin
    state_d        = state_q;
    proc_d         = proc_q;
    slice_d        = slice_q;
    ctx_pc_d       = ctx_pc_q;
    tbl_we         = 1'b0;
    Change_Context = 1'b0;
    unique case (state_q)
      StRun: begin
        if (Halt) begin
          state_d = StHold;
        end else if (decide) begin
          slice_d = Slice_Load;
          // Re-picking the running process only renews its quantum.
          if (pick_id != proc_q) begin
            tbl_we   = 1'b1;
            proc_d   = pick_id;
            ctx_pc_d = pc_tbl_q[pick_id];
            state_d  = StSwitch;
          end
        end else if (Slice_Load != '0) begin
          slice_d = slice_q - SLICE_W'(1);
        end
      end
      StSwitch: begin
        Change_Context = 1'b1;
        state_d        = Halt ? StHold : StRun;
      end
      StHold: begin
        if (!Halt) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // State, counter and PC table registers with synchronous reset.
  always_ff @(posedge Slow_Clock) begin
    if (Reset) begin
      state_q  <= StRun;
      proc_q   <= '0;
      slice_q  <= Slice_Load;
      ctx_pc_q <= '0;
      for (int unsigned i = 0; i < PROC_N; i++) begin
        pc_tbl_q[i] <= PC_W'(proc_base(proc_id_t'(i)));
      end
    end else begin
      state_q  <= state_d;
      proc_q   <= proc_d;
      slice_q  <= slice_d;
      ctx_pc_q <= ctx_pc_d;
      if (tbl_we) begin
        pc_tbl_q[proc_q] <= Current_PC;
      end
    end
  end

  assign Proc_ID     = proc_q;
  assign Context_PC  = ctx_pc_q;
  assign Slice_Count = slice_q;

endmodule

// File: tb/tb_context_scheduler.sv
// Self-checking bench for context_scheduler: directed scenarios with constant
// expectations plus a randomized run against a cycle-level reference model.
module tb_context_scheduler;

  logic        clk = 1'b0;
  logic        rst, halt, yield_r, tv;
  logic [3:0]  mask;
  logic [15:0] load;
  logic [1:0]  tid;
  logic [12:0] cur_pc;
  logic        cc;
  logic [1:0]  pid;
  logic [12:0] cpc;
  logic [15:0] scnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 = running, 1 = switching, 2 = halted.
  int m_phase, m_proc, m_slice, m_ctx;
  int m_tbl [4];

  context_scheduler dut (
    .Slow_Clock     (clk),
    .Reset          (rst),
    .Halt           (halt),
    .Enable_Mask    (mask),
    .Slice_Load     (load),
    .Yield          (yield_r),
    .Target_Valid   (tv),
    .Target_ID      (tid),
    .Current_PC     (cur_pc),
    .Change_Context (cc),
    .Proc_ID        (pid),
    .Context_PC     (cpc),
    .Slice_Count    (scnt)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int run, want, nxt;
    if (rst) begin
      m_phase = 0; m_proc = 0; m_slice = int'(load); m_ctx = 0;
      for (int i = 0; i < 4; i++) m_tbl[i] = i * 1024;
    end else if (m_phase == 1) begin
      m_phase = halt ? 2 : 0;
    end else if (m_phase == 2) begin
      if (!halt) m_phase = 0;
    end else if (halt) begin
      m_phase = 2;
    end else begin
      run  = int'(mask) | 1;
      want = int'(yield_r) | int'(m_slice == 1 && load != 0) | int'(((run >> m_proc) & 1) == 0);
      if (want != 0) begin
        nxt = -1;
        if (yield_r && tv && ((run >> tid) & 1) == 1) nxt = int'(tid);
        for (int k = 1; k <= 4; k++) begin
          if (nxt < 0 && ((run >> ((m_proc + k) % 4)) & 1) == 1) nxt = (m_proc + k) % 4;
        end
        m_slice = int'(load);
        if (nxt != m_proc) begin
          m_tbl[m_proc] = int'(cur_pc);
          m_proc  = nxt;
          m_ctx   = m_tbl[nxt];
          m_phase = 1;
        end
      end else if (load != 0) begin
        m_slice = (m_slice + 65535) % 65536;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] ld, input logic [3:0] mk);
    rst = 1'b1; halt = 1'b0; yield_r = 1'b0; tv = 1'b0; tid = 2'd0;
    load = ld; mask = mk; cur_pc = 13'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_yield(input logic [1:0] target, input logic [12:0] pc);
    yield_r = 1'b1; tv = 1'b1; tid = target; cur_pc = pc;
    tick();
    yield_r = 1'b0; tv = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(16'd5, 4'hF);
    n_cmp++; if (pid !== 2'd0) begin n_bad++; $display("FAIL reset_proc: got %0d want 0", pid); end
    n_cmp++; if (cpc !== 13'd0) begin n_bad++; $display("FAIL reset_ctx: got %0d want 0", cpc); end
    n_cmp++; if (cc !== 1'b0) begin n_bad++; $display("FAIL reset_cc: got %0b want 0", cc); end
    n_cmp++; if (scnt !== 16'd5) begin n_bad++; $display("FAIL reset_slice: got %0d want 5", scnt); end
  endtask

  task automatic test_round_robin();
    int cyc [$];
    int ids [$];
    do_reset(16'd5, 4'hF);
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (cc === 1'b1) begin cyc.push_back(i); ids.push_back(int'(pid)); end
    end
    n_cmp++;
    if (cyc.size() != 4) begin
      n_bad++; $display("FAIL rr_pulses: got %0d pulses want 4", cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (cyc[k] != 5 + 6 * k || ids[k] != (k + 1) % 4) begin
          n_bad++;
          $display("FAIL rr_pulse%0d: got cycle %0d proc %0d want cycle %0d proc %0d",
                   k, cyc[k], ids[k], 5 + 6 * k, (k + 1) % 4);
        end
      end
    end
  endtask

  task automatic test_yield_target();
    do_reset(16'd0, 4'hF);
    do_yield(2'd1, 13'd50);
    tick();
    do_yield(2'd3, 13'd1100);
    n_cmp++; if (pid !== 2'd3 || cpc !== 13'd3072 || cc !== 1'b1) begin
      n_bad++; $display("FAIL yield_to3: got proc %0d ctx %0d cc %0b want 3 3072 1", pid, cpc, cc);
    end
    tick();
    n_cmp++; if (cc !== 1'b0) begin n_bad++; $display("FAIL yield_pulse_len: got cc %0b want 0", cc); end
    do_yield(2'd1, 13'd3500);
    n_cmp++; if (pid !== 2'd1 || cpc !== 13'd1100) begin
      n_bad++; $display("FAIL yield_back1: got proc %0d ctx %0d want 1 1100", pid, cpc);
    end
    tick();
    do_yield(2'd0, 13'd4000);
    n_cmp++; if (cpc !== 13'd50) begin n_bad++; $display("FAIL yield_back0: got ctx %0d want 50", cpc); end
  endtask

  task automatic test_single_proc();
    int pulses = 0;
    int bad_slice = 0;
    do_reset(16'd3, 4'b0001);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (cc !== 1'b0) pulses++;
      if (int'(scnt) != 3 - (i % 3)) bad_slice++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL single_cc: got %0d pulses want 0", pulses); end
    n_cmp++; if (bad_slice != 0) begin n_bad++; $display("FAIL single_slice: got %0d bad cycles want 0", bad_slice); end
    n_cmp++; if (pid !== 2'd0) begin n_bad++; $display("FAIL single_proc: got %0d want 0", pid); end
  endtask

  task automatic test_mask_drop();
    do_reset(16'd0, 4'hF);
    do_yield(2'd2, 13'd10);
    tick();
    mask = 4'b1011;
    tick();
    n_cmp++; if (pid !== 2'd3 || cc !== 1'b1) begin
      n_bad++; $display("FAIL drop_to3: got proc %0d cc %0b want 3 1", pid, cc);
    end
    tick();
    mask = 4'hF;
    do_yield(2'd2, 13'd20);
    tick();
    mask = 4'b0011;
    tick();
    n_cmp++; if (pid !== 2'd0 || cc !== 1'b1) begin
      n_bad++; $display("FAIL drop_to0: got proc %0d cc %0b want 0 1", pid, cc);
    end
  endtask

  task automatic test_halt();
    int pulses = 0;
    int waited = 0;
    do_reset(16'd5, 4'hF);
    tick();
    halt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cc !== 1'b0) pulses++;
    end
    n_cmp++; if (scnt !== 16'd4 || pulses != 0) begin
      n_bad++; $display("FAIL halt_freeze: got slice %0d pulses %0d want 4 0", scnt, pulses);
    end
    halt = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    n_cmp++; if (scnt !== 16'd1 || cc !== 1'b0) begin
      n_bad++; $display("FAIL halt_resume_cnt: got slice %0d cc %0b want 1 0", scnt, cc);
    end
    while (cc !== 1'b1 && waited < 20) begin tick(); waited++; end
    n_cmp++; if (waited != 1 || pid !== 2'd1) begin
      n_bad++; $display("FAIL halt_expiry: got %0d extra cycles proc %0d want 1 1", waited, pid);
    end
  endtask

  task automatic test_reset_in_switch();
    do_reset(16'd0, 4'hF);
    do_yield(2'd1, 13'd100);
    tick();
    do_yield(2'd2, 13'd555);
    rst = 1'b1; load = 16'd7;
    tick();
    rst = 1'b0; load = 16'd0;
    n_cmp++; if (pid !== 2'd0 || cpc !== 13'd0 || cc !== 1'b0 || scnt !== 16'd7) begin
      n_bad++; $display("FAIL rst_switch: got proc %0d ctx %0d cc %0b slice %0d want 0 0 0 7",
                        pid, cpc, cc, scnt);
    end
    do_yield(2'd1, 13'd11);
    n_cmp++; if (cpc !== 13'd1024) begin n_bad++; $display("FAIL rst_base1: got %0d want 1024", cpc); end
    tick();
    do_yield(2'd2, 13'd12);
    n_cmp++; if (cpc !== 13'd2048) begin n_bad++; $display("FAIL rst_base2: got %0d want 2048", cpc); end
    tick();
    do_yield(2'd3, 13'd13);
    n_cmp++; if (cpc !== 13'd3072) begin n_bad++; $display("FAIL rst_base3: got %0d want 3072", cpc); end
  endtask

  task automatic test_random();
    do_reset(16'd4, 4'hF);
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      halt    = ($urandom_range(0, 15) == 0);
      yield_r = ($urandom_range(0, 5) == 0);
      tv      = $urandom_range(0, 1) == 1;
      tid     = 2'($urandom_range(0, 3));
      cur_pc  = 13'($urandom);
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) load = 16'($urandom_range(0, 6));
      tick();
      n_cmp++; if (int'(pid) != m_proc) begin
        n_bad++; $display("FAIL rand_proc@%0d: got %0d want %0d", i, pid, m_proc);
      end
      n_cmp++; if (int'(cpc) != m_ctx) begin
        n_bad++; $display("FAIL rand_ctx@%0d: got %0d want %0d", i, cpc, m_ctx);
      end
      n_cmp++; if (int'(scnt) != m_slice) begin
        n_bad++; $display("FAIL rand_slice@%0d: got %0d want %0d", i, scnt, m_slice);
      end
      n_cmp++; if (cc !== (m_phase == 1)) begin
        n_bad++; $display("FAIL rand_cc@%0d: got %0b want %0b", i, cc, m_phase == 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_yield_target();
    test_single_proc();
    test_mask_drop();
    test_halt();
    test_reset_in_switch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
